// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths, tap count, timeout and FSM state type for
//            gradient_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int ACC_W        = 12;
    localparam int MAG_W        = 8;
    localparam int N_TAPS       = 6;
    localparam int DONE_TIMEOUT = 4;
    localparam int PROD_W       = 10;
    // One counter serves both the tap count and the done-timeout count
    localparam int CNT_W        = $clog2(N_TAPS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tap_mult.sv
`default_nettype none
// ============================================================================
// Module   : tap_mult
// Brief    : Combinational signed 5-bit coefficient x unsigned 5-bit pixel.
// Revision : 1.0 - initial release
// ============================================================================
module tap_mult
    import conv_pkg::*;
(
    input  logic signed [4:0]        a,
    input  logic        [4:0]        b,
    output logic signed [PROD_W-1:0] prod
);

    // Pixel is zero-extended before entering the signed multiply
    assign prod = PROD_W'(a) * $signed(PROD_W'(b));

endmodule
`default_nettype wire

// File: rtl/gradient_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : gradient_accumulator
// Brief    : Six-tap signed multiply-accumulate with done handshake, timeout
//            and held result. Macro GRAD_SAT_EN saturates mag at 255.
// Revision : 1.0 - initial release
// ============================================================================
module gradient_accumulator
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    calc_enable,
    input  logic signed [4:0]       a,
    input  logic        [4:0]       b,
    input  logic                    calc_done,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] grad,
    output logic        [MAG_W-1:0] mag,
    output logic                    err
);

    localparam logic [CNT_W-1:0] C_LAST_TAP  = CNT_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(DONE_TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_grad;
    logic        [MAG_W-1:0]  r_mag;
    logic        [MAG_W-1:0]  w_mag;
    logic        [CNT_W-1:0]  r_cnt;
    logic        [ACC_W-1:0]  w_abs;
    logic signed [PROD_W-1:0] w_prod;
    logic                     r_err;
    logic                     w_last_tap;
    logic                     w_timeout;
    logic                     w_proto_err;

    tap_mult u_tap_mult (
        .a    (a),
        .b    (b),
        .prod (w_prod)
    );

    assign w_last_tap  = (r_cnt == C_LAST_TAP);
    assign w_timeout   = (r_state == WAIT_DONE) && !calc_done && (r_cnt == C_LAST_WAIT);
    assign w_proto_err = (calc_enable && (r_state != IDLE))
                       || (calc_done && ((r_state == IDLE) || (r_state == ACCUM)))
                       || w_timeout;

    assign w_abs = r_acc[ACC_W-1] ? -r_acc : r_acc;

`ifdef GRAD_SAT_EN
    assign w_mag = (|w_abs[ACC_W-1:MAG_W]) ? {MAG_W{1'b1}} : w_abs[MAG_W-1:0];
`else
    logic w_unused_abs_hi;
    assign w_unused_abs_hi = |w_abs[ACC_W-1:MAG_W];
    assign w_mag           = w_abs[MAG_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (calc_enable) w_next_state = ACCUM;
            ACCUM:     if (w_last_tap)  w_next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (calc_done)      w_next_state = HOLD;
                else if (w_timeout) w_next_state = IDLE;
            end
            HOLD:      if (out_ready)   w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_grad <= '0;
            r_mag  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_proto_err) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (calc_enable) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
                    // Counter restarts here so WAIT_DONE can reuse it for the timeout
                    r_cnt <= w_last_tap ? '0 : r_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (calc_done) begin
                        r_grad <= r_acc;
                        r_mag  <= w_mag;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == HOLD);
    assign grad      = r_grad;
    assign mag       = r_mag;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gradient_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_gradient_accumulator
// Brief    : Self-checking bench: vector table, random transactions against an
//            arithmetic reference, and handshake / error / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gradient_accumulator;

`ifdef GRAD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               calc_enable;
    logic signed [4:0]  a;
    logic        [4:0]  b;
    logic               calc_done;
    logic               out_ready;
    logic               out_valid;
    logic signed [11:0] grad;
    logic        [7:0]  mag;
    logic               err;

    int n_pass  = 0;
    int n_total = 0;

    gradient_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .calc_enable (calc_enable),
        .a           (a),
        .b           (b),
        .calc_done   (calc_done),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .grad        (grad),
        .mag         (mag),
        .err         (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] av;
        logic [29:0] bv;
        logic [1:0]  dly;
        logic [2:0]  rdy;
        int          g;
        int          m;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [29:0] pack6(input int x0, x1, x2, x3, x4, x5);
        logic [29:0] r;
        r[4:0]   = x0[4:0];
        r[9:5]   = x1[4:0];
        r[14:10] = x2[4:0];
        r[19:15] = x3[4:0];
        r[24:20] = x4[4:0];
        r[29:25] = x5[4:0];
        return r;
    endfunction

    function automatic vec_t mk(input logic [29:0] av, bv, input int dly, rdy, g, m);
        vec_t v;
        v.av  = av;
        v.bv  = bv;
        v.dly = dly[1:0];
        v.rdy = rdy[2:0];
        v.g   = g;
        v.m   = m;
        return v;
    endfunction

    function automatic int model_mag(input int g);
        int ab;
        ab = (g < 0) ? -g : g;
        if (SAT) return (ab > 255) ? 255 : ab;
        return ab % 256;
    endfunction

    // Start pulse then six taps; optional stray enable/done pulses and out_ready noise
    task automatic feed(input logic [29:0] av, bv, input int en_at, done_at, input bit noise);
        calc_enable = 1'b1;
        step();
        calc_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a           = av[i*5 +: 5];
            b           = bv[i*5 +: 5];
            calc_enable = (i == en_at);
            calc_done   = (i == done_at);
            out_ready   = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            step();
        end
        calc_enable = 1'b0;
        calc_done   = 1'b0;
        a           = '0;
        b           = '0;
    endtask

    task automatic complete(input int dly, rdy, eg, em, input bit exp_err, input string nm);
        for (int k = 0; k < dly; k++) step();
        chk({nm, " valid_before_done"}, int'(out_valid), 0);
        calc_done = 1'b1;
        out_ready = 1'b0;
        step();
        calc_done = 1'b0;
        chk({nm, " valid"}, int'(out_valid), 1);
        chk({nm, " grad"}, int'(grad), eg);
        chk({nm, " mag"}, int'(mag), em);
        for (int k = 0; k < rdy; k++) begin
            step();
            chk({nm, " valid_held"}, int'(out_valid), 1);
            chk({nm, " grad_held"}, int'(grad), eg);
            chk({nm, " mag_held"}, int'(mag), em);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, " valid_after_accept"}, int'(out_valid), 0);
        chk({nm, " err"}, int'(err), int'(exp_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [29:0] sob_a, sob_b, av, bv;
        int          g, seen;

        rst = 1'b1; calc_enable = 1'b0; calc_done = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset valid", int'(out_valid), 0);
        chk("reset grad", int'(grad), 0);
        chk("reset mag", int'(mag), 0);
        chk("reset err", int'(err), 0);

        sob_a = pack6(-1, -2, -1, 1, 2, 1);
        sob_b = pack6(15, 15, 15, 0, 0, 0);
        vecs[0] = mk(sob_a, sob_b, 1, 0, -60, 60);
        vecs[1] = mk(pack6(-16, -16, -16, 15, 15, 15), sob_b, 0, 0, -720, SAT ? 255 : 208);
        vecs[2] = mk(pack6(15, 15, 15, 15, 15, 15), pack6(15, 15, 15, 15, 15, 15), 3, 5, 1350, SAT ? 255 : 70);
        vecs[3] = mk(pack6(-16, -16, -16, -16, -16, -16), pack6(15, 15, 15, 15, 15, 15), 2, 1, -1440, SAT ? 255 : 160);
        vecs[4] = mk(pack6(3, -4, 5, 0, 7, -1), pack6(2, 3, 1, 9, 1, 4), 0, 2, 2, 2);
        vecs[5] = mk(pack6(5, -7, 9, 11, -13, 15), pack6(0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
        vecs[6] = mk(pack6(15, 15, 0, 0, 0, 0), pack6(15, 2, 0, 0, 0, 0), 0, 0, 255, 255);
        vecs[7] = mk(pack6(15, 15, 1, 0, 0, 0), pack6(15, 2, 1, 0, 0, 0), 0, 0, 256, SAT ? 255 : 0);
        vecs[8] = mk(pack6(-15, -15, 0, 0, 0, 0), pack6(15, 2, 0, 0, 0, 0), 3, 0, -255, 255);
        vecs[9] = mk(pack6(0, 0, 0, 0, 0, -1), pack6(0, 0, 0, 0, 0, 1), 0, 0, -1, 1);

        for (int v = 0; v < 10; v++) begin
            feed(vecs[v].av, vecs[v].bv, -1, -1, v[0]);
            complete(int'(vecs[v].dly), int'(vecs[v].rdy), vecs[v].g, vecs[v].m, 1'b0,
                     $sformatf("vec%0d", v));
        end

        for (int t = 0; t < 25; t++) begin
            g = 0;
            for (int i = 0; i < 6; i++) begin
                int ra, rb;
                ra = int'($urandom_range(31, 0)) - 16;
                rb = int'($urandom_range(15, 0));
                av[i*5 +: 5] = ra[4:0];
                bv[i*5 +: 5] = rb[4:0];
                g += ra * rb;
            end
            feed(av, bv, -1, -1, 1'b1);
            complete(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), g, model_mag(g),
                     1'b0, $sformatf("rand%0d", t));
        end

        // Stray start pulse on the third accumulate cycle
        feed(sob_a, sob_b, 2, -1, 1'b0);
        complete(1, 0, -60, 60, 1'b1, "en_in_accum");
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk("en_in_accum extra_results", seen, 0);

        // Reset on the fourth accumulate cycle clears everything including err
        calc_enable = 1'b1;
        step();
        calc_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 5'sd7; b = 5'd9;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_accum valid", int'(out_valid), 0);
        chk("rst_accum grad", int'(grad), 0);
        chk("rst_accum mag", int'(mag), 0);
        chk("rst_accum err", int'(err), 0);
        feed(sob_a, sob_b, -1, -1, 1'b0);
        complete(0, 0, -60, 60, 1'b0, "after_rst");

        // Reset while holding a result
        feed(sob_a, sob_b, -1, -1, 1'b0);
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        chk("rst_hold valid_before", int'(out_valid), 1);
        do_reset();
        chk("rst_hold valid", int'(out_valid), 0);
        chk("rst_hold grad", int'(grad), 0);

        // calc_done during accumulation flags err but leaves the sum alone
        feed(sob_a, sob_b, -1, 3, 1'b0);
        complete(0, 0, -60, 60, 1'b1, "done_in_accum");

        // calc_done in IDLE
        do_reset();
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        chk("done_in_idle err", int'(err), 1);

        // Withheld calc_done: err after the fourth silent WAIT_DONE cycle
        do_reset();
        feed(sob_a, sob_b, -1, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("timeout err_early", int'(err), 0);
            step();
        end
        chk("timeout err_before_last", int'(err), 0);
        step();
        chk("timeout err", int'(err), 1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            step();
        end
        chk("timeout no_result", seen, 0);
        feed(vecs[4].av, vecs[4].bv, -1, -1, 1'b0);
        complete(0, 0, 2, 2, 1'b1, "after_timeout");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
